// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : core_run_ctrl
// Brief   : Run sequencer, completion/watchdog detection and data-memory
//           arbiter between the host and the 9-bit-ISA core.
// Revision: 1.0
// ============================================================================
module core_run_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CW      = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_start,
  input  logic          host_abort,
  output logic          host_busy,
  output logic          host_done,
  output logic          host_timeout,
  output logic [CW-1:0] run_cycles,
  input  logic          hmem_req,
  input  logic          hmem_we,
  input  logic [AW-1:0] hmem_addr,
  input  logic [DW-1:0] hmem_wdata,
  output logic          hmem_gnt,
  output logic [DW-1:0] hmem_rdata,
  output logic          core_start,
  input  logic          core_done,
  input  logic          core_mem_read,
  input  logic          core_mem_write,
  input  logic [AW-1:0] core_mem_addr,
  input  logic [DW-1:0] core_mem_wdata,
  output logic [DW-1:0] core_mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  localparam logic [CW-1:0] c_LAST_CYCLE = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_run_cycles;
  logic          r_done_q;
  logic          w_core_owns;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_run_cycles <= '0;
      r_done_q     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done_q <= core_done;
      if (w_next == S_ARM)
        r_run_cycles <= '0;
      // The exit cycle is not counted, so the count freezes at the last RUN value.
      else if (r_state == S_RUN && w_next == S_RUN)
        r_run_cycles <= r_run_cycles + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_TMO: if (host_start) w_next = S_ARM;
      S_ARM:                 w_next = S_RUN;
      S_RUN: begin
        if (host_abort)                 w_next = S_IDLE;
        else if (!r_done_q && core_done) w_next = S_DONE;
        else if (r_run_cycles == c_LAST_CYCLE) w_next = S_TMO;
      end
      default:               w_next = S_IDLE;
    endcase
  end

  assign w_core_owns  = (r_state == S_ARM) || (r_state == S_RUN);
  assign host_busy    = w_core_owns;
  assign host_done    = (r_state == S_DONE);
  assign host_timeout = (r_state == S_TMO);
  assign core_start   = (r_state == S_ARM);
  assign run_cycles   = r_run_cycles;

  assign hmem_gnt  = !w_core_owns && hmem_req;
  assign mem_read  = w_core_owns ? core_mem_read  : (hmem_req && !hmem_we);
  assign mem_write = w_core_owns ? core_mem_write : (hmem_req && hmem_we);
  assign mem_addr  = w_core_owns ? core_mem_addr  : hmem_addr;
  assign mem_wdata = w_core_owns ? core_mem_wdata : hmem_wdata;

  assign hmem_rdata     = mem_rdata;
  assign core_mem_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_run_ctrl
// Brief   : Self-checking bench for core_run_ctrl with a behavioural model
//           and a small data memory.
// Revision: 1.0
// ============================================================================
module tb_core_run_ctrl;
  localparam int AW = 8, DW = 8, CW = 10, TIMEOUT = 1000;
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DONE = 3, P_TMO = 4;

  logic clk = 0, reset = 0;
  logic host_start = 0, host_abort = 0;
  logic host_busy, host_done, host_timeout;
  logic [CW-1:0] run_cycles;
  logic hmem_req = 0, hmem_we = 0;
  logic [AW-1:0] hmem_addr = 0;
  logic [DW-1:0] hmem_wdata = 0;
  logic hmem_gnt;
  logic [DW-1:0] hmem_rdata;
  logic core_start, core_done = 0, core_mem_read = 0, core_mem_write = 0;
  logic [AW-1:0] core_mem_addr = 0;
  logic [DW-1:0] core_mem_wdata = 0, core_mem_rdata;
  logic mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total = 0, bad = 0;
  bit rand_traffic = 0;
  logic [DW-1:0] tbmem [256];

  core_run_ctrl #(.AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .host_start(host_start), .host_abort(host_abort),
    .host_busy(host_busy), .host_done(host_done), .host_timeout(host_timeout),
    .run_cycles(run_cycles), .hmem_req(hmem_req), .hmem_we(hmem_we),
    .hmem_addr(hmem_addr), .hmem_wdata(hmem_wdata), .hmem_gnt(hmem_gnt),
    .hmem_rdata(hmem_rdata), .core_start(core_start), .core_done(core_done),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
    .core_mem_rdata(core_mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // Data memory with combinational read.
  initial for (int i = 0; i < 256; i++) tbmem[i] = '0;
  always @(posedge clk) if (mem_write) tbmem[mem_addr] <= mem_wdata;
  assign mem_rdata = tbmem[mem_addr];

  // Behavioural model: current phase, RUN cycles spent, and last core_done seen.
  int  m_phase = P_IDLE;
  int  m_cnt   = 0;
  bit  m_prev_done = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= P_IDLE; m_cnt <= 0; m_prev_done <= 0;
    end else begin
      m_prev_done <= core_done;
      if (m_phase == P_ARM) m_phase <= P_RUN;
      else if (m_phase == P_RUN) begin
        if (host_abort) m_phase <= P_IDLE;
        else if (core_done && !m_prev_done) m_phase <= P_DONE;
        else if (m_cnt + 1 >= TIMEOUT) m_phase <= P_TMO;
        else m_cnt <= m_cnt + 1;
      end else if (host_start) begin
        m_phase <= P_ARM; m_cnt <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit core_owns;
    logic [AW-1:0] ea;
    core_owns = (m_phase == P_ARM) || (m_phase == P_RUN);
    ea = core_owns ? core_mem_addr : hmem_addr;
    chk("busy", host_busy, core_owns);
    chk("done", host_done, m_phase == P_DONE);
    chk("timeout", host_timeout, m_phase == P_TMO);
    chk("core_start", core_start, m_phase == P_ARM);
    chk("run_cycles", run_cycles, m_cnt);
    chk("hmem_gnt", hmem_gnt, !core_owns && hmem_req);
    chk("mem_read", mem_read, core_owns ? core_mem_read : (hmem_req && !hmem_we));
    chk("mem_write", mem_write, core_owns ? core_mem_write : (hmem_req && hmem_we));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, core_owns ? core_mem_wdata : hmem_wdata);
    chk("hmem_rdata", hmem_rdata, tbmem[ea]);
    chk("core_mem_rdata", core_mem_rdata, tbmem[ea]);
  endtask

  always @(negedge clk) check_all();

  task automatic rand_bus();
    hmem_req       = ($urandom_range(0, 1) == 1);
    hmem_we        = ($urandom_range(0, 1) == 1);
    hmem_addr      = AW'($urandom);
    hmem_wdata     = DW'($urandom);
    core_mem_read  = ($urandom_range(0, 1) == 1);
    core_mem_write = ($urandom_range(0, 3) == 0);
    core_mem_addr  = AW'($urandom);
    core_mem_wdata = DW'($urandom);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_traffic) rand_bus();
    end
  endtask

  initial begin
    step(2);
    reset = 1;
    step(1);

    // Reset mid-RUN
    host_start = 1; step(1); host_start = 0;
    step(1); step(5);
    chk("t1_cnt5", run_cycles, 5);
    hmem_req = 1; hmem_we = 0;
    #3 reset = 0; #1;
    chk("t1_busy", host_busy, 0);
    chk("t1_core_start", core_start, 0);
    chk("t1_cnt0", run_cycles, 0);
    chk("t1_gnt", hmem_gnt, 1);
    check_all();
    step(1); reset = 1; hmem_req = 0;
    step(1);

    // Host load, run to core_done after 37 cycles, readback
    hmem_req = 1; hmem_we = 1; hmem_addr = 8'd4; hmem_wdata = 8'hA5; step(1);
    hmem_req = 0; hmem_we = 0;
    host_start = 1; step(1); host_start = 0;
    chk("t2_core_start", core_start, 1);
    step(1);
    chk("t2_core_start_fall", core_start, 0);
    step(37);
    core_done = 1; step(1);
    chk("t2_done", host_done, 1);
    chk("t2_cnt37", run_cycles, 37);
    hmem_req = 1; hmem_addr = 8'd4; #1;
    chk("t2_read_gnt", hmem_gnt, 1);
    chk("t2_read_data", hmem_rdata, 8'hA5);
    step(1); hmem_req = 0;

    // core_done already high on RUN entry
    host_start = 1; step(1); host_start = 0;
    step(1); step(3);
    chk("t3_still_run", host_busy, 1);
    core_done = 0; step(9);
    core_done = 1; step(1);
    chk("t3_done", host_done, 1);
    chk("t3_cnt12", run_cycles, 12);
    core_done = 0; step(1);

    // Host locked out during RUN; abort beats a done edge
    host_start = 1; step(1); host_start = 0;
    rand_traffic = 1; step(4); rand_traffic = 0;
    hmem_req = 1; core_mem_addr = 8'h3C; #1;
    chk("t5_gnt_run", hmem_gnt, 0);
    chk("t5_addr_core", mem_addr, 8'h3C);
    core_done = 1; step(1);
    chk("t5_gnt_done", hmem_gnt, 1);
    core_done = 0; host_start = 1; step(1); host_start = 0;
    step(3);
    core_done = 1; host_abort = 1; step(1);
    host_abort = 0; core_done = 0; hmem_req = 0;
    chk("t5_abort_busy", host_busy, 0);
    chk("t5_abort_done", host_done, 0);

    // Watchdog
    host_start = 1; step(1); host_start = 0;
    step(1); step(999);
    chk("t4_pre_tmo", host_timeout, 0);
    step(1);
    chk("t4_tmo", host_timeout, 1);
    chk("t4_cnt999", run_cycles, 999);
    step(3);
    chk("t4_frozen", run_cycles, 999);

    // Randomized control and traffic
    rand_traffic = 1;
    for (int i = 0; i < 4000; i++) begin
      host_start = ($urandom_range(0, 7) == 0);
      host_abort = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 11) == 0) core_done = ~core_done;
      step(1);
    end
    rand_traffic = 0;
    host_start = 0; host_abort = 0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
